// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle unsigned magnitude comparator: walks 2-bit slices MSB first,
// stopping at the first differing slice; result flags are held until the next start.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_eq_B,
  output logic             A_lt_B,
  output logic             A_gt_B
);

  localparam int NS = WIDTH / 2;
  localparam int PW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]    ptr;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;

  always_comb begin
    slice_a = a_reg[{ptr, 1'b0} +: 2];
    slice_b = b_reg[{ptr, 1'b0} +: 2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      ptr    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      A_eq_B <= 1'b0;
      A_lt_B <= 1'b0;
      A_gt_B <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg  <= A;
            b_reg  <= B;
            ptr    <= PW'(NS - 1);
            A_eq_B <= 1'b0;
            A_lt_B <= 1'b0;
            A_gt_B <= 1'b0;
            busy   <= 1'b1;
            state  <= COMPARE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        COMPARE: begin
          // start is deliberately not looked at here: latched operands stay put
          if (slice_a > slice_b) begin
            A_gt_B <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (slice_a < slice_b) begin
            A_lt_B <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (ptr == '0) begin
            A_eq_B <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            ptr <= ptr - PW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (WIDTH=8, four slices).
module tb_serial_magnitude_comparator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       a_eq_b;
  logic       a_lt_b;
  logic       a_gt_b;

  int unsigned passed;
  int unsigned total;

  // {busy, done, eq, lt, gt}
  logic [4:0] obs;
  assign obs = {busy, done, a_eq_b, a_lt_b, a_gt_b};

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (a),
    .B      (b),
    .busy   (busy),
    .done   (done),
    .A_eq_B (a_eq_b),
    .A_lt_B (a_lt_b),
    .A_gt_B (a_gt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    #12;
    total++;
    if (obs !== 5'b00000) $display("FAIL reset: got %b want %b", obs, 5'b00000);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== 5'b00000) $display("FAIL reset_idle: got %b want %b", obs, 5'b00000);
    else passed++;
  endtask

  // A=B=0xB4: equal all the way down, 4 edges; flags held two extra idle edges
  task automatic test_equal;
    logic [4:0] exp;
    @(negedge clk);
    a = 8'hB4; b = 8'hB4; start = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      a = 8'h00; b = 8'hFF;
      exp = (j < 4) ? 5'b10000 : (j == 4) ? 5'b01100 : 5'b00100;
      total++;
      if (obs !== exp) $display("FAIL equal edge+%0d: got %b want %b", j, obs, exp);
      else passed++;
    end
  endtask

  // 0x80 vs 0x7F: MSB slice 2 vs 1 decides after one edge
  task automatic test_msb_gt;
    logic [4:0] exp;
    @(negedge clk);
    a = 8'h80; b = 8'h7F; start = 1'b1;
    for (int j = 0; j <= 2; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp = (j < 1) ? 5'b10000 : (j == 1) ? 5'b01001 : 5'b00001;
      total++;
      if (obs !== exp) $display("FAIL msb_gt edge+%0d: got %b want %b", j, obs, exp);
      else passed++;
    end
  endtask

  // 0x12 vs 0x13: only slice 0 differs (2 vs 3)
  task automatic test_lsb_lt;
    logic [4:0] exp;
    @(negedge clk);
    a = 8'h12; b = 8'h13; start = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp = (j < 4) ? 5'b10000 : (j == 4) ? 5'b01010 : 5'b00010;
      total++;
      if (obs !== exp) $display("FAIL lsb_lt edge+%0d: got %b want %b", j, obs, exp);
      else passed++;
    end
  endtask

  // second start during COMPARE must not replace 0x40/0x00
  task automatic test_ignored_start;
    logic [4:0] exp;
    @(negedge clk);
    a = 8'h40; b = 8'h00; start = 1'b1;
    for (int j = 0; j <= 2; j++) begin
      @(posedge clk); #1;
      if (j == 0) begin
        a = 8'h00; b = 8'hFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      exp = (j < 1) ? 5'b10000 : (j == 1) ? 5'b01001 : 5'b00001;
      total++;
      if (obs !== exp) $display("FAIL ignored_start edge+%0d: got %b want %b", j, obs, exp);
      else passed++;
    end
  endtask

  task automatic test_reset_abort;
    logic [4:0] exp;
    @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 5'b00000) $display("FAIL abort_immediate: got %b want %b", obs, 5'b00000);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== 5'b00000) $display("FAIL abort_no_done cyc%0d: got %b want %b", j, obs, 5'b00000);
      else passed++;
    end
    @(negedge clk);
    a = 8'h03; b = 8'h03; start = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp = (j < 4) ? 5'b10000 : (j == 4) ? 5'b01100 : 5'b00100;
      total++;
      if (obs !== exp) $display("FAIL post_abort_eq edge+%0d: got %b want %b", j, obs, exp);
      else passed++;
    end
  endtask

  // 0x00 vs 0xC0 gives lt after 1 edge; start held in DONE launches 0x05 vs 0x04
  task automatic test_back_to_back;
    logic [4:0] exp;
    @(negedge clk);
    a = 8'h00; b = 8'hC0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (obs !== 5'b10000) $display("FAIL b2b_first_busy: got %b want %b", obs, 5'b10000);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (obs !== 5'b01010) $display("FAIL b2b_first_done: got %b want %b", obs, 5'b01010);
    else passed++;
    a = 8'h05; b = 8'h04; start = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp = (j < 4) ? 5'b10000 : (j == 4) ? 5'b01001 : 5'b00001;
      total++;
      if (obs !== exp) $display("FAIL b2b_second edge+%0d: got %b want %b", j, obs, exp);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_equal();
    test_msb_gt();
    test_lsb_lt();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
